// File: rtl/sd_req_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_req_queue_pkg
// Description : Shared definitions for the SD request queue: register word
//               indices, control/status bit positions, dispatch FSM states
//               and queue entry layouts.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_req_queue_pkg;

    // Register word indices (reg_addr[6:3])
    localparam logic [3:0] c_word_sd     = 4'd0;
    localparam logic [3:0] c_word_dma    = 4'd1;
    localparam logic [3:0] c_word_blk    = 4'd2;
    localparam logic [3:0] c_word_ctrl   = 4'd3;
    localparam logic [3:0] c_word_stat   = 4'd4;
    localparam logic [3:0] c_word_res    = 4'd5;
    localparam logic [3:0] c_word_irqen  = 4'd6;
    localparam logic [3:0] c_word_irqclr = 4'd7;

    // Control word bits
    localparam int c_ctrl_push  = 0;
    localparam int c_ctrl_wr    = 1;
    localparam int c_ctrl_flush = 2;

    // Interrupt pending bit positions
    localparam int c_pend_res  = 0;
    localparam int c_pend_idle = 1;
    localparam int c_pend_ovf  = 2;

    // Status word layout
    localparam int c_st_pend_lsb  = 0;
    localparam int c_st_busy      = 3;
    localparam int c_st_cmd_empty = 4;
    localparam int c_st_cmd_full  = 5;
    localparam int c_st_res_empty = 6;
    localparam int c_st_cnt_lsb   = 7;
    localparam int c_st_cnt_w     = 5;
    localparam int c_st_ovf       = 12;

    // Result word layout
    localparam int c_res_ok      = 8;
    localparam int c_res_cnt_lsb = 9;
    localparam int c_res_cnt_w   = 7;

    localparam logic [63:0] c_bad_word = 64'h0000_0000_DEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Non-address part of a command entry
    typedef struct packed {
        logic       wr;
        logic [7:0] tag;
    } cmd_ctl_t;

    // Result queue entry
    typedef struct packed {
        logic [7:0] tag;
        logic       ok;
    } res_entry_t;

endpackage
`default_nettype wire

// File: rtl/sd_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sd_req_fifo
// Description : Power-of-two circular FIFO with occupancy count and a flush
//               that can optionally keep the current head entry.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_push / i_wdata  - write (ignored when full or flushing)
//               i_pop             - remove head (ignored when empty)
//               i_flush           - discard entries
//               i_keep_head       - on flush, keep the head entry
//               o_rdata           - head entry
//               o_count/o_full/o_empty - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sd_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic                     i_keep_head,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one = 1;
    localparam logic [c_aw:0]   c_cnt_one = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_rd;
    logic [c_aw-1:0]  r_wr;
    logic [c_aw:0]    r_cnt;

    logic            w_push;
    logic            w_pop;
    logic            w_keep;
    logic [c_aw-1:0] w_rd_nxt;

    assign o_full   = (r_cnt == c_cnt_one << c_aw);
    assign o_empty  = (r_cnt == '0);
    assign o_count  = r_cnt;
    assign o_rdata  = r_mem[r_rd];

    assign w_push   = i_push && !o_full && !i_flush;
    assign w_pop    = i_pop && !o_empty;
    assign w_rd_nxt = w_pop ? r_rd + c_ptr_one : r_rd;
    // A head that completes in the same cycle as the flush is gone anyway.
    assign w_keep   = i_keep_head && !o_empty && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= w_rd_nxt;
            r_wr  <= w_keep ? w_rd_nxt + c_ptr_one : w_rd_nxt;
            r_cnt <= w_keep ? c_cnt_one : '0;
        end else begin
            if (w_push) r_wr <= r_wr + c_ptr_one;
            if (w_pop)  r_rd <= r_rd + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/sd_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : sd_req_queue
// Description : Register-programmed SD request queue. Software stages a
//               request in words 0-2 and pushes it via word 3; a dispatch FSM
//               issues queue heads to the SD engine and records {tag, ok}
//               completions in a result queue read through word 5.
// Ports       : msoc_clk/sys_rst - clock, synchronous active-high reset
//               reg_*            - register access (read data one cycle late)
//               req_*            - head request to the engine (valid/ready)
//               resp_*           - completion from the engine (valid/ready)
//               irq              - registered interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module sd_req_queue
    import sd_req_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int BLKCNT_W = 23
) (
    input  logic                msoc_clk,
    input  logic                sys_rst,
    input  logic                reg_en,
    input  logic [7:0]          reg_we,
    input  logic [15:0]         reg_addr,
    input  logic [63:0]         reg_wrdata,
    output logic [63:0]         reg_rddata,
    output logic [ADDR_W-1:0]   req_addr_sd,
    output logic [ADDR_W-1:0]   req_addr_dma,
    output logic [BLKCNT_W-1:0] req_blkcnt,
    output logic                req_wr,
    output logic                req_val,
    input  logic                req_rdy,
    input  logic                resp_ok,
    input  logic                resp_val,
    output logic                resp_rdy,
    output logic                irq
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam int c_cmd_w = 2 * ADDR_W + BLKCNT_W + $bits(cmd_ctl_t);
    localparam int c_res_w = $bits(res_entry_t);

    logic [ADDR_W-1:0]   r_stg_sd;
    logic [ADDR_W-1:0]   r_stg_dma;
    logic [BLKCNT_W-1:0] r_stg_blk;
    logic [7:0]          r_tag;
    logic                r_ovf;
    logic [2:0]          r_irq_en;
    logic                r_irq;
    state_t              r_state;
    state_t              w_state_nxt;

    logic               w_wr_access;
    logic [3:0]         w_word;
    logic               w_ctrl_wr;
    logic               w_flush;
    logic               w_push_req;
    logic               w_cmd_push;
    logic               w_cmd_pop;
    logic               w_res_push;
    logic               w_res_pop;
    logic [2:0]         w_irq_pend;
    logic [63:0]        w_status;
    logic [63:0]        w_res_word;

    cmd_ctl_t           w_ctl_in;
    cmd_ctl_t           w_ctl_head;
    logic [c_cmd_w-1:0] w_cmd_wdata;
    logic [c_cmd_w-1:0] w_cmd_rdata;
    logic [c_cnt_w-1:0] w_cmd_cnt;
    logic               w_cmd_full;
    logic               w_cmd_empty;

    res_entry_t         w_res_in;
    res_entry_t         w_res_head;
    logic [c_res_w-1:0] w_res_rdata;
    logic [c_cnt_w-1:0] w_res_cnt;
    logic               w_res_full;
    logic               w_res_empty;

    logic               w_unused_ok;

    assign w_wr_access = reg_en && (reg_we != 8'h00);
    assign w_word      = reg_addr[6:3];
    assign w_ctrl_wr   = w_wr_access && (w_word == c_word_ctrl);
    assign w_flush     = w_ctrl_wr && reg_wrdata[c_ctrl_flush];
    // Flush wins over push in the same control write.
    assign w_push_req  = w_ctrl_wr && reg_wrdata[c_ctrl_push] && !reg_wrdata[c_ctrl_flush];
    assign w_cmd_push  = w_push_req && !w_cmd_full;
    assign w_res_pop   = w_wr_access && (w_word == c_word_res) && reg_wrdata[0];

    assign w_ctl_in    = '{wr: reg_wrdata[c_ctrl_wr], tag: r_tag};
    assign w_cmd_wdata = {r_stg_sd, r_stg_dma, r_stg_blk, w_ctl_in};
    assign {req_addr_sd, req_addr_dma, req_blkcnt, w_ctl_head} = w_cmd_rdata;
    assign req_wr      = w_ctl_head.wr;

    assign w_res_in    = '{tag: w_ctl_head.tag, ok: resp_ok};
    assign w_res_head  = w_res_rdata;

    assign w_unused_ok = &{1'b0, reg_addr, reg_wrdata};

    sd_req_fifo #(.WIDTH(c_cmd_w), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk         (msoc_clk),
        .rst         (sys_rst),
        .i_push      (w_cmd_push),
        .i_wdata     (w_cmd_wdata),
        .i_pop       (w_cmd_pop),
        .i_flush     (w_flush),
        .i_keep_head (r_state != S_IDLE),
        .o_rdata     (w_cmd_rdata),
        .o_count     (w_cmd_cnt),
        .o_full      (w_cmd_full),
        .o_empty     (w_cmd_empty)
    );

    sd_req_fifo #(.WIDTH(c_res_w), .DEPTH(DEPTH)) u_res_fifo (
        .clk         (msoc_clk),
        .rst         (sys_rst),
        .i_push      (w_res_push),
        .i_wdata     (w_res_in),
        .i_pop       (w_res_pop),
        .i_flush     (1'b0),
        .i_keep_head (1'b0),
        .o_rdata     (w_res_rdata),
        .o_count     (w_res_cnt),
        .o_full      (w_res_full),
        .o_empty     (w_res_empty)
    );

    // ---------------- dispatch FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        req_val     = 1'b0;
        resp_rdy    = 1'b0;
        w_cmd_pop   = 1'b0;
        w_res_push  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A concurrent flush empties the queue, so do not start on it.
                if (!w_cmd_empty && !w_flush) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                req_val = 1'b1;
                if (req_rdy) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                resp_rdy = !w_res_full;
                if (resp_val && !w_res_full) begin
                    w_res_push  = 1'b1;
                    w_cmd_pop   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- status / result words ----------------
    always_comb begin
        w_irq_pend              = '0;
        w_irq_pend[c_pend_res]  = !w_res_empty;
        w_irq_pend[c_pend_idle] = w_cmd_empty && (r_state == S_IDLE);
        w_irq_pend[c_pend_ovf]  = r_ovf;

        w_status                             = '0;
        w_status[c_st_pend_lsb +: 3]         = w_irq_pend;
        w_status[c_st_busy]                  = (r_state != S_IDLE);
        w_status[c_st_cmd_empty]             = w_cmd_empty;
        w_status[c_st_cmd_full]              = w_cmd_full;
        w_status[c_st_res_empty]             = w_res_empty;
        w_status[c_st_cnt_lsb +: c_st_cnt_w] = c_st_cnt_w'(w_cmd_cnt);
        w_status[c_st_ovf]                   = r_ovf;

        w_res_word = '0;
        if (!w_res_empty) begin
            w_res_word[7:0]                        = w_res_head.tag;
            w_res_word[c_res_ok]                   = w_res_head.ok;
            w_res_word[c_res_cnt_lsb +: c_res_cnt_w] = c_res_cnt_w'(w_res_cnt);
        end
    end

    // ---------------- control registers ----------------
    always_ff @(posedge msoc_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_stg_sd  <= '0;
            r_stg_dma <= '0;
            r_stg_blk <= '0;
            r_tag     <= '0;
            r_ovf     <= 1'b0;
            r_irq_en  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_access) begin
                case (w_word)
                    c_word_sd:    r_stg_sd  <= reg_wrdata[ADDR_W-1:0];
                    c_word_dma:   r_stg_dma <= reg_wrdata[ADDR_W-1:0];
                    c_word_blk:   r_stg_blk <= reg_wrdata[BLKCNT_W-1:0];
                    c_word_irqen: r_irq_en  <= reg_wrdata[2:0];
                    default: ;
                endcase
            end
            if (w_cmd_push) r_tag <= r_tag + 8'd1;
            // A new overflow outranks a clear arriving in the same cycle.
            if (w_push_req && w_cmd_full)
                r_ovf <= 1'b1;
            else if (w_wr_access && (w_word == c_word_irqclr) && reg_wrdata[c_pend_ovf])
                r_ovf <= 1'b0;
            r_irq <= |(r_irq_en & w_irq_pend);
        end
    end

    // ---------------- register read ----------------
    always_ff @(posedge msoc_clk) begin
        if (sys_rst) begin
            reg_rddata <= '0;
        end else if (reg_en && (reg_we == 8'h00)) begin
            case (w_word)
                c_word_stat:  reg_rddata <= w_status;
                c_word_res:   reg_rddata <= w_res_word;
                c_word_irqen: reg_rddata <= {61'd0, r_irq_en};
                default:      reg_rddata <= c_bad_word;
            endcase
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sd_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_req_queue
// Description : Directed self-checking bench for sd_req_queue (default
//               parameters: DEPTH 4, ADDR_W 32, BLKCNT_W 23).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_req_queue;

    localparam logic [31:0] c_sd  = 32'h1000_0040;
    localparam logic [31:0] c_dma = 32'h8000_1000;

    logic        msoc_clk = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        reg_en   = 1'b0;
    logic [7:0]  reg_we   = 8'h00;
    logic [15:0] reg_addr = 16'h0000;
    logic [63:0] reg_wrdata = 64'd0;
    logic [63:0] reg_rddata;
    logic [31:0] req_addr_sd;
    logic [31:0] req_addr_dma;
    logic [22:0] req_blkcnt;
    logic        req_wr;
    logic        req_val;
    logic        req_rdy  = 1'b0;
    logic        resp_ok  = 1'b0;
    logic        resp_val = 1'b0;
    logic        resp_rdy;
    logic        irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] rd;

    sd_req_queue dut (
        .msoc_clk     (msoc_clk),
        .sys_rst      (sys_rst),
        .reg_en       (reg_en),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wrdata   (reg_wrdata),
        .reg_rddata   (reg_rddata),
        .req_addr_sd  (req_addr_sd),
        .req_addr_dma (req_addr_dma),
        .req_blkcnt   (req_blkcnt),
        .req_wr       (req_wr),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .resp_ok      (resp_ok),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .irq          (irq)
    );

    always #5 msoc_clk = ~msoc_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wr_reg(input int w, input logic [63:0] d);
        reg_en = 1'b1; reg_we = 8'hFF; reg_addr = 16'(w * 8); reg_wrdata = d;
        @(posedge msoc_clk); #1;
        reg_en = 1'b0; reg_we = 8'h00; reg_wrdata = 64'd0;
    endtask

    task automatic rd_reg(input int w, output logic [63:0] d);
        reg_en = 1'b1; reg_we = 8'h00; reg_addr = 16'(w * 8);
        @(posedge msoc_clk); #1;
        d = reg_rddata;
        reg_en = 1'b0;
    endtask

    task automatic wait_req(input string who);
        for (int i = 0; i < 20 && req_val !== 1'b1; i++) begin
            @(posedge msoc_clk); #1;
        end
        n_cmp++;
        if (req_val !== 1'b1) begin
            n_bad++; $display("FAIL %s req_val wait: got %b want 1", who, req_val);
        end
    endtask

    // Accept the head request and return one completion.
    task automatic serve(input logic ok, input logic exp_wr, input string who);
        wait_req(who);
        n_cmp++;
        if (req_addr_sd !== c_sd) begin
            n_bad++; $display("FAIL %s req_addr_sd: got %h want %h", who, req_addr_sd, c_sd);
        end
        n_cmp++;
        if (req_wr !== exp_wr) begin
            n_bad++; $display("FAIL %s req_wr: got %b want %b", who, req_wr, exp_wr);
        end
        req_rdy = 1'b1;
        @(posedge msoc_clk); #1;
        req_rdy = 1'b0;
        for (int i = 0; i < 20 && resp_rdy !== 1'b1; i++) begin
            @(posedge msoc_clk); #1;
        end
        n_cmp++;
        if (resp_rdy !== 1'b1) begin
            n_bad++; $display("FAIL %s resp_rdy wait: got %b want 1", who, resp_rdy);
        end
        resp_val = 1'b1; resp_ok = ok;
        @(posedge msoc_clk); #1;
        resp_val = 1'b0; resp_ok = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge msoc_clk);
        #1;
        n_cmp++;
        if ({req_val, resp_rdy, irq} !== 3'b000) begin
            n_bad++; $display("FAIL reset_outs: got %b want 000", {req_val, resp_rdy, irq});
        end
        n_cmp++;
        if (reg_rddata !== 64'd0) begin
            n_bad++; $display("FAIL reset_rddata: got %h want 0", reg_rddata);
        end
        sys_rst = 1'b0;
        // cmd_empty, res_empty and the idle/empty pending bit are all set
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h52) begin
            n_bad++; $display("FAIL reset_status: got %h want 52", rd);
        end
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'd0) begin
            n_bad++; $display("FAIL reset_res: got %h want 0", rd);
        end
        rd_reg(0, rd);
        n_cmp++;
        if (rd !== 64'hDEAD_BEEF) begin
            n_bad++; $display("FAIL word0_read: got %h want deadbeef", rd);
        end
        rd_reg(9, rd);
        n_cmp++;
        if (rd !== 64'hDEAD_BEEF) begin
            n_bad++; $display("FAIL word9_read: got %h want deadbeef", rd);
        end
        wr_reg(6, 64'hFF);
        rd_reg(6, rd);
        n_cmp++;
        if (rd !== 64'h7) begin
            n_bad++; $display("FAIL irq_en_rw: got %h want 7", rd);
        end
        wr_reg(6, 64'h0);
        @(posedge msoc_clk); #1;
    endtask

    task automatic test_basic();
        wr_reg(0, {32'hFFFF_FFFF, c_sd});
        wr_reg(1, {32'h0, c_dma});
        wr_reg(2, 64'hFFFF_FFFF_FFC0_0005);
        wr_reg(3, 64'h3);
        wr_reg(3, 64'h1);
        wr_reg(3, 64'h1);
        n_cmp++;
        if ({req_val, req_addr_dma, req_blkcnt} !== {1'b1, c_dma, 23'h40_0005}) begin
            n_bad++; $display("FAIL basic_head: got %b %h %h want 1 %h 400005",
                              req_val, req_addr_dma, req_blkcnt, c_dma);
        end
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h1C8) begin
            n_bad++; $display("FAIL basic_status: got %h want 1c8", rd);
        end
        serve(1'b1, 1'b1, "basic0");
        serve(1'b0, 1'b0, "basic1");
        serve(1'b1, 1'b0, "basic2");
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h700) begin
            n_bad++; $display("FAIL basic_res0: got %h want 700", rd);
        end
        wr_reg(5, 64'h1);
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h401) begin
            n_bad++; $display("FAIL basic_res1: got %h want 401", rd);
        end
        wr_reg(5, 64'h1);
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h302) begin
            n_bad++; $display("FAIL basic_res2: got %h want 302", rd);
        end
        wr_reg(5, 64'h1);
        wr_reg(5, 64'h1);   // pop on empty is ignored
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'd0) begin
            n_bad++; $display("FAIL basic_res_empty: got %h want 0", rd);
        end
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h52) begin
            n_bad++; $display("FAIL basic_status_end: got %h want 52", rd);
        end
    endtask

    task automatic test_overflow();
        wr_reg(6, 64'h4);
        for (int i = 0; i < 5; i++) wr_reg(3, 64'h1);
        for (int k = 0; k < 2 && irq !== 1'b1; k++) begin
            @(posedge msoc_clk); #1;
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++; $display("FAIL ovf_irq: got %b want 1", irq);
        end
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h126C) begin
            n_bad++; $display("FAIL ovf_status: got %h want 126c", rd);
        end
        wr_reg(7, 64'h4);
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h268) begin
            n_bad++; $display("FAIL ovf_clear_status: got %h want 268", rd);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL ovf_clear_irq: got %b want 0", irq);
        end
        for (int i = 0; i < 4; i++) serve(1'b1, 1'b0, "ovf_drain");
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h903) begin
            n_bad++; $display("FAIL ovf_res_head: got %h want 903", rd);
        end
        for (int i = 0; i < 4; i++) wr_reg(5, 64'h1);
        wr_reg(6, 64'h0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) wr_reg(3, 64'h1);
        wait_req("flush");
        req_rdy = 1'b1;
        @(posedge msoc_clk); #1;
        req_rdy = 1'b0;
        wr_reg(3, 64'h4);
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'hC8) begin
            n_bad++; $display("FAIL flush_status: got %h want c8", rd);
        end
        n_cmp++;
        if (resp_rdy !== 1'b1) begin
            n_bad++; $display("FAIL flush_resp_rdy: got %b want 1", resp_rdy);
        end
        resp_val = 1'b1; resp_ok = 1'b1;
        @(posedge msoc_clk); #1;
        resp_val = 1'b0; resp_ok = 1'b0;
        repeat (4) @(posedge msoc_clk);
        #1;
        n_cmp++;
        if (req_val !== 1'b0) begin
            n_bad++; $display("FAIL flush_no_reissue: got %b want 0", req_val);
        end
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h13) begin
            n_bad++; $display("FAIL flush_status_end: got %h want 13", rd);
        end
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h307) begin
            n_bad++; $display("FAIL flush_res: got %h want 307", rd);
        end
        wr_reg(5, 64'h1);
    endtask

    task automatic test_res_full();
        for (int i = 0; i < 4; i++) begin
            wr_reg(3, 64'h1);
            serve(1'b1, 1'b0, "fill");
        end
        wr_reg(3, 64'h1);
        wait_req("full5");
        req_rdy = 1'b1;
        @(posedge msoc_clk); #1;
        req_rdy = 1'b0;
        resp_val = 1'b1; resp_ok = 1'b0;
        repeat (3) @(posedge msoc_clk);
        #1;
        n_cmp++;
        if (resp_rdy !== 1'b0) begin
            n_bad++; $display("FAIL full_hold: got %b want 0", resp_rdy);
        end
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h89) begin
            n_bad++; $display("FAIL full_status: got %h want 89", rd);
        end
        wr_reg(5, 64'h1);
        n_cmp++;
        if (resp_rdy !== 1'b1) begin
            n_bad++; $display("FAIL full_release: got %b want 1", resp_rdy);
        end
        @(posedge msoc_clk); #1;
        resp_val = 1'b0;
        n_cmp++;
        if (resp_rdy !== 1'b0) begin
            n_bad++; $display("FAIL full_accepted: got %b want 0", resp_rdy);
        end
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h90B) begin
            n_bad++; $display("FAIL full_res_head: got %h want 90b", rd);
        end
        for (int i = 0; i < 3; i++) wr_reg(5, 64'h1);
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h20E) begin
            n_bad++; $display("FAIL full_res_last: got %h want 20e", rd);
        end
        wr_reg(5, 64'h1);
    endtask

    task automatic test_back_to_back();
        wr_reg(3, 64'h1);
        wait_req("b2b");
        req_rdy = 1'b1;
        @(posedge msoc_clk); #1;
        req_rdy = 1'b0;
        resp_val = 1'b1; resp_ok = 1'b1;
        wr_reg(3, 64'h1);          // push on the completion/pop edge
        resp_val = 1'b0; resp_ok = 1'b0;
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h81) begin
            n_bad++; $display("FAIL b2b_status: got %h want 81", rd);
        end
        serve(1'b0, 1'b0, "b2b2");
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h50F) begin
            n_bad++; $display("FAIL b2b_res0: got %h want 50f", rd);
        end
        wr_reg(5, 64'h1);
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'h210) begin
            n_bad++; $display("FAIL b2b_res1: got %h want 210", rd);
        end
        wr_reg(5, 64'h1);
    endtask

    task automatic test_reset_in_wait();
        wr_reg(6, 64'h1);
        wr_reg(3, 64'h1);
        serve(1'b1, 1'b0, "rstw0");
        wr_reg(3, 64'h1);
        wait_req("rstw1");
        req_rdy = 1'b1;
        @(posedge msoc_clk); #1;
        req_rdy = 1'b0;
        n_cmp++;
        if ({resp_rdy, irq} !== 2'b11) begin
            n_bad++; $display("FAIL rstw_pre: got %b want 11", {resp_rdy, irq});
        end
        sys_rst = 1'b1;
        @(posedge msoc_clk); #1;
        n_cmp++;
        if ({req_val, resp_rdy, irq} !== 3'b000) begin
            n_bad++; $display("FAIL rstw_outs: got %b want 000", {req_val, resp_rdy, irq});
        end
        sys_rst = 1'b0;
        repeat (3) @(posedge msoc_clk);
        #1;
        n_cmp++;
        if (req_val !== 1'b0) begin
            n_bad++; $display("FAIL rstw_no_issue: got %b want 0", req_val);
        end
        rd_reg(4, rd);
        n_cmp++;
        if (rd !== 64'h52) begin
            n_bad++; $display("FAIL rstw_status: got %h want 52", rd);
        end
        rd_reg(5, rd);
        n_cmp++;
        if (rd !== 64'd0) begin
            n_bad++; $display("FAIL rstw_res: got %h want 0", rd);
        end
        rd_reg(6, rd);
        n_cmp++;
        if (rd !== 64'd0) begin
            n_bad++; $display("FAIL rstw_irq_en: got %h want 0", rd);
        end
    endtask

    // Staging registers were cleared by reset: reload the SD address.
    task automatic test_tag_wrap();
        wr_reg(0, {32'd0, c_sd});
        for (int i = 0; i < 257; i++) begin
            wr_reg(3, 64'h1);
            serve(1'b1, 1'b0, "wrap");
            rd_reg(5, rd);
            n_cmp++;
            if (rd !== (64'h300 | 64'(i % 256))) begin
                n_bad++; $display("FAIL wrap_tag[%0d]: got %h want %h", i, rd, 64'h300 | 64'(i % 256));
            end
            wr_reg(5, 64'h1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_flush();
        test_res_full();
        test_back_to_back();
        test_reset_in_wait();
        test_tag_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
